// File: rtl/floor_display_scan_ctrl.sv
// floor_display_scan_ctrl: 4-digit floor/direction scan with frame-aligned commit and direction blink
module floor_display_scan_ctrl #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLINK_FRAMES = 128
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       load,
   input  logic [3:0] floor_in,
   input  logic [1:0] dir_in,
   output logic [3:0] an,
   output logic [4:0] code_out,
   output logic       frame_tick,
   output logic       update_pending
);
   localparam int PW = $clog2(REFRESH_DIV);
   localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BMAX = BW'(BLINK_FRAMES - 1);
   logic [PW-1:0] presc_q, presc_d;
   logic [BW-1:0] blink_q, blink_d;
   logic [1:0] idx_q, idx_d, dir_q, dir_d, pdir_q, pdir_d;
   logic [3:0] floor_q, floor_d, pfloor_q, pfloor_d, an_q, an_d;
   logic [4:0] code_q, code_d, fcode, dcode, code_sel;
   logic hidden_q, hidden_d, pend_q, pend_d, tick_q, tick_d;
   logic dark, term, boundary, commit, restart;
   assign an             = an_q;
   assign code_out       = code_q;
   assign frame_tick     = tick_q;
   assign update_pending = pend_q;
   // Outputs are built from next-state values so a commit shows from the digit 0 slot it opens
   always_comb begin
      dark     = &an_q;
      term     = presc_q == PMAX;
      boundary = enable && !dark && term && idx_q == 2'd3;
      commit   = enable ? boundary && (pend_q || load) : load;
      pfloor_d = load ? floor_in : pfloor_q;
      pdir_d   = load ? dir_in : pdir_q;
      floor_d  = commit ? pfloor_d : floor_q;
      dir_d    = commit ? pdir_d : dir_q;
      pend_d   = !commit && (load || pend_q);
      restart  = commit && dir_d != dir_q;
      presc_d  = (!enable || dark || term) ? '0 : presc_q + 1'b1;
      idx_d    = (!enable || dark) ? 2'd0 : idx_q + {1'b0, term};
      blink_d  = restart ? '0 : !boundary ? blink_q : blink_q == BMAX ? '0 : blink_q + 1'b1;
      hidden_d = !restart && (hidden_q ^ (boundary && blink_q == BMAX));
      fcode    = floor_d == 4'd0 ? 5'd0 : floor_d <= 4'd9 ? {1'b0, floor_d} : 5'd31;
      dcode    = dir_d == 2'b00 ? 5'd10 : (dir_d == 2'b11 || hidden_d) ? 5'd0 :
                 dir_d == 2'b01 ? 5'd11 : 5'd12;
      code_sel = idx_d == 2'd3 ? fcode : idx_d == 2'd0 ? dcode : 5'd0;
      an_d     = enable ? ~(4'b0001 << idx_d) : 4'b1111;
      code_d   = enable ? code_sel : 5'd0;
      tick_d   = boundary;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q  <= '0;
         blink_q  <= '0;
         idx_q    <= 2'd0;
         dir_q    <= 2'b00;
         pdir_q   <= 2'b00;
         floor_q  <= 4'd0;
         pfloor_q <= 4'd0;
         an_q     <= 4'b1111;
         code_q   <= 5'd0;
         hidden_q <= 1'b0;
         pend_q   <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         blink_q  <= blink_d;
         idx_q    <= idx_d;
         dir_q    <= dir_d;
         pdir_q   <= pdir_d;
         floor_q  <= floor_d;
         pfloor_q <= pfloor_d;
         an_q     <= an_d;
         code_q   <= code_d;
         hidden_q <= hidden_d;
         pend_q   <= pend_d;
         tick_q   <= tick_d;
      end
   end
endmodule

// File: tb/tb_floor_display_scan_ctrl.sv
// tb_floor_display_scan_ctrl: scoreboard bench, expected per-cycle outputs queued by stimulus, checked by monitor
module tb_floor_display_scan_ctrl;
   localparam int S = 2;
   typedef struct {
      int         c;
      logic [3:0] an;
      logic [4:0] code;
      logic       tick;
      logic       pend;
   } exp_t;
   logic       clk, rst_n, enable, load;
   logic [3:0] floor_in;
   logic [1:0] dir_in;
   logic [3:0] an;
   logic [4:0] code_out;
   logic       frame_tick, update_pending;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   done = 0;
   exp_t q[$];

   floor_display_scan_ctrl #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
      .floor_in(floor_in), .dir_in(dir_in), .an(an), .code_out(code_out),
      .frame_tick(frame_tick), .update_pending(update_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic exp1(int rel, logic [3:0] a, logic [4:0] c, logic t, logic p);
      exp_t e;
      e.c = S + rel; e.an = a; e.code = c; e.tick = t; e.pend = p;
      q.push_back(e);
   endtask

   task automatic push_frame(int st, logic [4:0] d0, logic [4:0] d3, logic tk, int pat, int len);
      for (int j = 0; j < len; j++) begin
         int dg;
         dg = j / 4;
         exp1(st + j, ~(4'b0001 << dg), dg == 0 ? d0 : dg == 3 ? d3 : 5'd0, tk && j == 0, j >= pat);
      end
   endtask

   task automatic go(int n);
      do @(negedge clk); while (cyc < S + n - 1);
   endtask

   task automatic ld(int n, logic [3:0] f, logic [1:0] d);
      go(n);
      load = 1'b1; floor_in = f; dir_in = d;
      go(n + 1);
      load = 1'b0;
   endtask

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].c < cyc) begin
         checks++; errors++;
         $display("FAIL missed_slot cyc=%0d actual=none required=slot %0d", cyc, q[0].c);
         void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].c == cyc) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if ({an, code_out, frame_tick, update_pending} !== {e.an, e.code, e.tick, e.pend}) begin
            errors++;
            $display("FAIL scan_out edge=%0d actual an=%b code=%0d tick=%b pend=%b required an=%b code=%0d tick=%b pend=%b",
                     cyc - S, an, code_out, frame_tick, update_pending, e.an, e.code, e.tick, e.pend);
         end
      end
      if (done) begin
         checks++;
         if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d left required=0", q.size());
         end
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; enable = 1'b1; load = 1'b0; floor_in = 4'd0; dir_in = 2'b00;
      exp1(-1, 4'b1111, 5'd0, 1'b0, 1'b0);
      exp1(0, 4'b1111, 5'd0, 1'b0, 1'b0);
      push_frame(1, 5'd10, 5'd0, 1'b0, 16, 16);
      push_frame(17, 5'd10, 5'd0, 1'b1, 5, 16);
      go(1);
      rst_n = 1'b1;
      push_frame(33, 5'd10, 5'd7, 1'b1, 7, 16);
      ld(22, 4'd7, 2'b00);
      push_frame(49, 5'd11, 5'd3, 1'b1, 16, 16);
      push_frame(65, 5'd11, 5'd3, 1'b1, 16, 16);
      push_frame(81, 5'd0, 5'd3, 1'b1, 16, 16);
      push_frame(97, 5'd0, 5'd3, 1'b1, 16, 16);
      push_frame(113, 5'd11, 5'd3, 1'b1, 3, 16);
      ld(40, 4'd3, 2'b01);
      push_frame(129, 5'd11, 5'd5, 1'b1, 6, 16);
      push_frame(145, 5'd10, 5'd31, 1'b1, 16, 16);
      ld(116, 4'd4, 2'b01);
      ld(120, 4'd9, 2'b01);
      ld(129, 4'd5, 2'b01);
      ld(135, 4'd12, 2'b00);
      for (int i = 161; i < 166; i++) exp1(i, 4'b1111, 5'd0, 1'b0, 1'b0);
      push_frame(166, 5'd12, 5'd2, 1'b0, 4, 9);
      for (int i = 175; i < 178; i++) exp1(i, 4'b1111, 5'd0, 1'b0, 1'b0);
      push_frame(178, 5'd10, 5'd0, 1'b0, 16, 16);
      go(161);
      enable = 1'b0;
      ld(163, 4'd2, 2'b10);
      go(166);
      enable = 1'b1;
      ld(170, 4'd8, 2'b01);
      go(175);
      @(posedge clk);
      #2 rst_n = 1'b0;
      go(178);
      rst_n = 1'b1;
      go(198);
      done = 1'b1;
   end
endmodule

// File: doc/floor_display_scan_ctrl.md
Name: floor_display_scan_ctrl

Overview:
- Time-multiplexes one shared binary-to-seven-segment decoder across a 4-digit common-anode display.
- Shows an elevator-style status: digit 3 holds the floor number (1-9), digits 2 and 1 are blank, and digit 0 holds the direction symbol (stable/up/down).
- Latches new status from the system controller through a load strobe and commits it only at frame boundaries, so a scan never shows mixed old/new data.
- Blinks the direction symbol while the car is moving.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays selected; legal range 2 or more.
- BLINK_FRAMES, 128, complete scan frames per blink half-period; legal range 1 or more.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  1 = scan the display; 0 = display dark.
- load  input  1  single-cycle strobe; captures floor_in and dir_in.
- floor_in  input  4  floor number; valid range 1-9.
- dir_in  input  2  00 = stable, 01 = up, 10 = down, 11 = blank.
- an  output  4  digit anodes, active-low, one-hot-low while scanning.
- code_out  output  5  decoder input code: 0 blank, 1-9 digits, 10 stable, 11 up, 12 down, 31 error.
- frame_tick  output  1  one-cycle pulse at each frame boundary.
- update_pending  output  1  captured data is waiting for the next commit.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - an=4'b1111, code_out=0, frame_tick=0, update_pending=0.
  - Prescaler=0, scan index=0, blink counter=0, blink phase=visible.
  - Committed floor=0, committed dir=00; pending registers cleared.
- All outputs are registered.
  - First rising edge with rst_n=1 and enable=1: an=4'b1110 (digit 0) and the matching code_out.
  - an and code_out change on the same edge.
- Scan:
  - Prescaler counts 0 to REFRESH_DIV-1.
  - At terminal count, scan index advances 0→1→2→3→0 (wraps).
  - Digit k is driven as an[k]=0 for exactly REFRESH_DIV cycles.
- Frame boundary: prescaler terminal count while scan index=3.
  - frame_tick=1 on the edge where an returns to 4'b1110.
  - Blink counter increments at each frame boundary.
  - When the counter reaches BLINK_FRAMES-1 it clears and the blink phase toggles.
- Code mapping (from committed registers):
  - Digit 3: committed floor if 1-9; 0 when floor=0 (post-reset blank); 31 for 10-15.
  - Digits 2 and 1: always 0 (blank).
  - Digit 0: dir 00→10; 01→11; 10→12; 11→0.
  - Codes 11 and 12 are replaced by 0 while blink phase=hidden.
  - Stable (10) never blinks.
- Load / commit:
  - load=1 captures floor_in and dir_in into pending registers and sets update_pending=1.
  - A later load before commit overwrites the pending data; last one wins.
  - At a frame boundary with update_pending=1: pending data copies to committed registers and update_pending=0. New codes appear from the digit 0 slot that starts on that edge.
  - load in the same cycle as a commit: the load's data is committed directly and update_pending ends at 0.
  - A commit whose dir differs from the old committed dir resets the blink counter to 0 and the blink phase to visible.
- Enable:
  - enable=0: next edge an=4'b1111 and code_out=0; prescaler and scan index held at 0; frame_tick=0.
  - While enable=0, a load commits immediately on its own edge and update_pending stays 0.
  - When enable rises, scanning restarts at digit 0 on the next edge.
- Reset mid-frame: asynchronous return to the reset state; pending data is lost.

Test Plan (REFRESH_DIV=4, BLINK_FRAMES=2):
- Release reset with enable=1 → an cycles 1110,1101,1011,0111 for 4 cycles each; code_out=10,0,0,0; frame_tick pulses every 16 cycles.
- load with floor_in=7, dir_in=00 in mid-frame → update_pending=1 until the next frame boundary; from then code_out=10,0,0,7; the old frame is never mixed with the new data.
- Commit dir=01, floor=3 → digit 0 shows 11 for 2 frames, then 0 for 2 frames, repeating; digit 3 steady at 3.
- Two loads before a boundary (floor 4 then floor 9), then a load of floor 5 exactly on the boundary cycle → floor 5 committed, update_pending=0.
- floor_in=12 committed → digit 3 code_out=31; enable=0 → an=1111 and code_out=0 next cycle; a load while disabled commits immediately.
- Assert rst_n=0 mid-digit-2 with data pending → an=1111 and update_pending=0 immediately, without waiting for a clock; restart shows floor blank (code 0) and stable (10).
